// File: rtl/tdm_pair_demux.sv
// Receive-side demux for a 2:1 time-multiplexed bus: rebuilds aligned A/B
// pairs and counts broken sequences (orphan B, repeated A).
module tdm_pair_demux #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_y,
  input  logic             i_sel,
  input  logic             i_valid,
  input  logic             i_clear,
  output logic [N-1:0]     o_a,
  output logic [N-1:0]     o_b,
  output logic             o_pair_valid,
  output logic             o_err,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_err_cnt
);

  // state  | meaning
  // WAIT_A | no A sample pending
  // GOT_A  | A sample held in hold_q, waiting for its B
  typedef enum logic {WAIT_A = 1'b0, GOT_A = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [N-1:0]     hold_q, hold_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             pair_valid_q, pair_valid_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic take_a;
  logic take_b;
  logic seq_err;

  // Gating by i_valid first keeps an undriven i_sel from leaking into state.
  assign take_a  = i_valid && !i_sel;
  assign take_b  = i_valid && i_sel;
  assign seq_err = ((state_q == WAIT_A) && take_b) || ((state_q == GOT_A) && take_a);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A: if (take_a) state_d = GOT_A;
      GOT_A:  if (take_b) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_comb begin
    hold_d       = hold_q;
    a_d          = a_q;
    b_d          = b_q;
    pair_valid_d = 1'b0;
    err_d        = seq_err;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;

    // A repeated A simply replaces the older one; the error is flagged separately.
    if (take_a) hold_d = i_y;

    if ((state_q == GOT_A) && take_b) begin
      a_d          = hold_q;
      b_d          = i_y;
      pair_valid_d = 1'b1;
    end

    // An error in the clear cycle wins over the clear.
    if (seq_err) begin
      err_sticky_d = 1'b1;
      if (i_clear)                 err_cnt_d = CNT_ONE;
      else if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
    end else if (i_clear) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      pair_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      hold_q       <= hold_d;
      a_q          <= a_d;
      b_q          <= b_d;
      pair_valid_q <= pair_valid_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_a          = a_q;
  assign o_b          = b_q;
  assign o_pair_valid = pair_valid_q;
  assign o_err        = err_q;
  assign o_err_sticky = err_sticky_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_tdm_pair_demux.sv
// Self-checking bench for tdm_pair_demux: directed scenarios plus random
// traffic compared against a sample-level pairing model.
module tb_tdm_pair_demux;
  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [N-1:0]     i_y = '0;
  logic             i_sel = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_clear = 1'b0;
  logic [N-1:0]     o_a, o_b;
  logic             o_pair_valid, o_err, o_err_sticky;
  logic [CNT_W-1:0] o_err_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sample-level view of the pairing rules.
  bit       m_pending;
  int       m_hold, m_a, m_b, m_cnt;
  bit       m_pv, m_err, m_sticky;

  tdm_pair_demux #(.N(N), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_y(i_y), .i_sel(i_sel),
    .i_valid(i_valid), .i_clear(i_clear), .o_a(o_a), .o_b(o_b),
    .o_pair_valid(o_pair_valid), .o_err(o_err), .o_err_sticky(o_err_sticky),
    .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [18:0] obs_vec();
    return {o_a, o_b, o_pair_valid, o_err, o_err_sticky, o_err_cnt};
  endfunction

  function automatic logic [18:0] exp_vec();
    return {N'(m_a), N'(m_b), m_pv, m_err, m_sticky, CNT_W'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_pending = 0; m_hold = 0; m_a = 0; m_b = 0;
    m_pv = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit valid, input bit sel, input int y, input bit clear);
    m_pv = 0;
    m_err = 0;
    if (valid) begin
      if (!sel) begin
        if (m_pending) m_err = 1;
        m_hold = y;
        m_pending = 1;
      end else if (m_pending) begin
        m_a = m_hold;
        m_b = y;
        m_pv = 1;
        m_pending = 0;
      end else begin
        m_err = 1;
      end
    end
    if (clear) begin
      m_cnt = 0;
      m_sticky = 0;
    end
    if (m_err) begin
      m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
      m_sticky = 1;
    end
  endtask

  // Drive one cycle of inputs, clock it in, update the model; sampling point is edge+1.
  task automatic step(input bit valid, input bit sel, input int y, input bit clear);
    i_valid = valid;
    i_sel   = sel;
    i_y     = N'(y);
    i_clear = clear;
    @(posedge i_clk);
    #1;
    model_step(valid, sel, y, clear);
    i_valid = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_clear = 1'b0;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    model_reset();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (obs_vec() !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", obs_vec());
    end
  endtask

  task automatic test_pair_basic();
    do_reset();
    step(1, 0, 3, 0);
    vectors++;
    if (o_pair_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_no_early_pv: got %b want 0", o_pair_valid);
    end
    step(1, 1, 12, 0);
    vectors++;
    if ({o_a, o_b, o_pair_valid, o_err, o_err_cnt} !== {4'd3, 4'd12, 1'b1, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL basic_pair: got a=%0d b=%0d pv=%b err=%b cnt=%0d want a=3 b=12 pv=1 err=0 cnt=0",
               o_a, o_b, o_pair_valid, o_err, o_err_cnt);
    end
    step(0, 0, 0, 0);
    vectors++;
    if ({o_a, o_b, o_pair_valid} !== {4'd3, 4'd12, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_pv_one_cycle: got a=%0d b=%0d pv=%b want a=3 b=12 pv=0", o_a, o_b, o_pair_valid);
    end
  endtask

  task automatic test_back_to_back();
    int seq_y[4] = '{1, 2, 5, 9};
    logic [9:0] exp_pv_ab[4];
    exp_pv_ab[0] = {1'b0, 4'd0, 4'd0, 1'b0};
    exp_pv_ab[1] = {1'b1, 4'd1, 4'd2, 1'b0};
    exp_pv_ab[2] = {1'b0, 4'd1, 4'd2, 1'b0};
    exp_pv_ab[3] = {1'b1, 4'd5, 4'd9, 1'b0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, k[0], seq_y[k], 0);
      vectors++;
      if ({o_pair_valid, o_a, o_b, o_err} !== exp_pv_ab[k]) begin
        miscompares++;
        $display("FAIL b2b_%0d: got pv=%b a=%0d b=%0d err=%b want %b", k, o_pair_valid, o_a, o_b, o_err, exp_pv_ab[k]);
      end
    end
  endtask

  task automatic test_repeated_a();
    do_reset();
    step(1, 0, 2, 0);
    step(1, 1, 8, 0);
    step(1, 0, 7, 0);
    step(1, 0, 4, 0);
    vectors++;
    if ({o_err, o_err_sticky, o_err_cnt, o_a, o_b, o_pair_valid} !== {1'b1, 1'b1, 8'd1, 4'd2, 4'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL repeat_a_err: got err=%b sticky=%b cnt=%0d a=%0d b=%0d pv=%b want 1 1 1 2 8 0",
               o_err, o_err_sticky, o_err_cnt, o_a, o_b, o_pair_valid);
    end
    step(1, 1, 15, 0);
    vectors++;
    if ({o_a, o_b, o_pair_valid, o_err, o_err_cnt} !== {4'd4, 4'd15, 1'b1, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL repeat_a_pair: got a=%0d b=%0d pv=%b err=%b cnt=%0d want 4 15 1 0 1",
               o_a, o_b, o_pair_valid, o_err, o_err_cnt);
    end
  endtask

  task automatic test_orphan_clear();
    do_reset();
    step(1, 1, 6, 0);
    vectors++;
    if ({o_err, o_err_cnt, o_err_sticky, o_a, o_b, o_pair_valid} !== {1'b1, 8'd1, 1'b1, 4'd0, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL orphan_b: got err=%b cnt=%0d sticky=%b a=%0d b=%0d pv=%b want 1 1 1 0 0 0",
               o_err, o_err_cnt, o_err_sticky, o_a, o_b, o_pair_valid);
    end
    step(0, 0, 0, 1);
    vectors++;
    if ({o_err, o_err_cnt, o_err_sticky} !== {1'b0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL clear: got err=%b cnt=%0d sticky=%b want 0 0 0", o_err, o_err_cnt, o_err_sticky);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(1, 1, k & 15, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL sat_step_%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (o_err_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_value: got cnt=%0d want 255", o_err_cnt);
    end
    step(1, 1, 1, 1);
    vectors++;
    if ({o_err_cnt, o_err_sticky, o_err} !== {8'd1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL clear_vs_err: got cnt=%0d sticky=%b err=%b want 1 1 1", o_err_cnt, o_err_sticky, o_err);
    end
  endtask

  task automatic test_reset_mid_pair();
    do_reset();
    step(1, 0, 10, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (obs_vec() !== 19'd0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got %h want 0", obs_vec());
    end
    #10;
    i_rst_n = 1'b1;
    model_reset();
    @(posedge i_clk);
    #1;
    step(1, 1, 3, 0);
    vectors++;
    if ({o_err, o_err_cnt, o_pair_valid, o_a, o_b} !== {1'b1, 8'd1, 1'b0, 4'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL midpair_orphan: got err=%b cnt=%0d pv=%b a=%0d b=%0d want 1 1 0 0 0",
               o_err, o_err_cnt, o_pair_valid, o_a, o_b);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      bit v, s, c;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) < 5);
      c = ($urandom_range(0, 31) == 0);
      step(v, s, int'($urandom_range(0, 15)), c);
      if (!v) begin
        i_y   = 'x;
        i_sel = 'x;
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pair_basic();
    test_back_to_back();
    test_repeated_a();
    test_orphan_clear();
    test_saturation();
    test_reset_mid_pair();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
